// File: rtl/gpu_pkg.sv
// rtl/gpu_pkg.sv - shared frame definitions for the scheduler broadcast
// Purpose: frame type enum, frame width and strobe decode shared by the
//          scheduler and every core_frame_receiver.
// Contents: FRAME_W, frame_type_t, rx_state_t, strobe_type()
package gpu_pkg;

  localparam int FRAME_W = 16;

  typedef enum logic [1:0] {
    FT_INS     = 2'd0,
    FT_MASK_R0 = 2'd1,
    FT_MASK_AC = 2'd2,
    FT_R0      = 2'd3
  } frame_type_t;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_SHIFT     = 2'd1,
    ST_ERR_DRAIN = 2'd2
  } rx_state_t;

  // Strobe vector order is {val_ins, val_mask_R0, val_mask_ac, val_R0}.
  // Only meaningful when exactly one bit is set.
  function automatic frame_type_t strobe_type(input logic [3:0] s);
    frame_type_t t;
    t = FT_INS;
    if (s[2]) t = FT_MASK_R0;
    if (s[1]) t = FT_MASK_AC;
    if (s[0]) t = FT_R0;
    return t;
  endfunction

endpackage

// File: rtl/ins_fifo.sv
// rtl/ins_fifo.sv - synchronous instruction FIFO with show-ahead head
// Purpose: stores completed instruction frames until the core consumes them.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   push, push_data      write request and data (ignored when full without pop)
//   pop                  consume head (ignored when empty)
//   pop_data             current head entry, stable until popped
//   full, empty, count   occupancy status
module ins_fifo
  import gpu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         pop_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == (AW+1)'(DEPTH));
  assign empty    = (count == '0);
  // Push while full succeeds only when the head leaves in the same cycle.
  assign do_push  = push && (!full || pop);
  assign do_pop   = pop && !empty;
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (do_pop) begin
        rd_ptr <= rd_ptr + AW'(1);
      end
      case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/core_frame_receiver.sv
// rtl/core_frame_receiver.sv - per-core deserialiser for the scheduler broadcast
// Purpose: shifts the serial instruction stream into frames, classifies them by
//          strobe, latches masks / R0 value and queues instructions for this core.
// Ports:
//   clk, reset                       clock, asynchronous active-high reset
//   core_id                          static index of this core in mask frames
//   val_ins/val_mask_R0/val_mask_ac/val_R0, instruction   serial frame input
//   rtr                              room for one more full instruction frame
//   ins_valid, ins_data, ins_ready   instruction FIFO head handshake
//   core_active                      this core's bit of the last active mask
//   r0_load, r0_value                R0 update pulse and value
//   err                              sticky protocol/overflow error
module core_frame_receiver
  import gpu_pkg::*;
#(
  parameter int FRAME_W    = gpu_pkg::FRAME_W,
  parameter int FIFO_DEPTH = 8,
  parameter int CORE_ID_W  = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [CORE_ID_W-1:0] core_id,
  input  logic                 val_ins,
  input  logic                 val_mask_R0,
  input  logic                 val_mask_ac,
  input  logic                 val_R0,
  input  logic                 instruction,
  output logic                 rtr,
  output logic                 ins_valid,
  output logic [FRAME_W-1:0]   ins_data,
  input  logic                 ins_ready,
  output logic                 core_active,
  output logic                 r0_load,
  output logic [FRAME_W-1:0]   r0_value,
  output logic                 err
);

  localparam int CNT_W = $clog2(FRAME_W);
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(FRAME_W - 1);

  rx_state_t            state;
  frame_type_t          ftype;
  frame_type_t          cur_type;
  logic [CNT_W-1:0]     count;
  logic [FRAME_W-2:0]   shreg;
  logic                 r0_sel;

  logic [3:0]           strobes;
  logic                 any_strobe;
  logic                 one_hot;
  logic                 multi;
  logic                 frame_done;
  logic [FRAME_W-1:0]   frame_word;
  logic                 push;
  logic                 pop;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [OCC_W-1:0]     fifo_count;

  assign strobes    = {val_ins, val_mask_R0, val_mask_ac, val_R0};
  assign any_strobe = |strobes;
  assign one_hot    = any_strobe && ((strobes & (strobes - 4'd1)) == 4'd0);
  assign multi      = any_strobe && !one_hot;
  assign cur_type   = strobe_type(strobes);
  assign frame_word = {shreg, instruction};

  // The last bit completes the frame combinationally so the FIFO write and
  // mask/R0 registers all land on the same edge that samples it.
  assign frame_done = (state == ST_SHIFT) && one_hot && (cur_type == ftype) &&
                      (count == LAST_BIT);
  assign push       = frame_done && (ftype == FT_INS) && core_active;
  assign pop        = ins_valid && ins_ready;
  assign ins_valid  = !fifo_empty;

  // Holding back at DEPTH-1 while a frame is in flight leaves room for it.
  assign rtr = (fifo_count <= OCC_W'(FIFO_DEPTH - 2)) ||
               ((fifo_count == OCC_W'(FIFO_DEPTH - 1)) && (state != ST_SHIFT));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_IDLE;
      ftype       <= FT_INS;
      count       <= '0;
      shreg       <= '0;
      core_active <= 1'b0;
      r0_sel      <= 1'b0;
      r0_value    <= '0;
      r0_load     <= 1'b0;
      err         <= 1'b0;
    end else begin
      r0_load <= 1'b0;
      if (push && fifo_full && !pop) begin
        err <= 1'b1;
      end
      case (state)
        ST_IDLE: begin
          if (multi) begin
            err   <= 1'b1;
            state <= ST_ERR_DRAIN;
          end else if (one_hot) begin
            shreg <= {{(FRAME_W-2){1'b0}}, instruction};
            ftype <= cur_type;
            count <= CNT_W'(1);
            state <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (multi) begin
            err   <= 1'b1;
            count <= '0;
            state <= ST_ERR_DRAIN;
          end else if (!any_strobe) begin
            count <= '0;
            state <= ST_IDLE;
          end else if (cur_type != ftype) begin
            // A different strobe abandons the partial frame and starts anew.
            shreg <= {{(FRAME_W-2){1'b0}}, instruction};
            ftype <= cur_type;
            count <= CNT_W'(1);
          end else begin
            shreg <= frame_word[FRAME_W-2:0];
            count <= count + CNT_W'(1);
            if (count == LAST_BIT) begin
              state <= ST_IDLE;
              case (ftype)
                FT_MASK_AC: core_active <= frame_word[core_id];
                FT_MASK_R0: r0_sel      <= frame_word[core_id];
                FT_R0: begin
                  if (r0_sel) begin
                    r0_value <= frame_word;
                    r0_load  <= 1'b1;
                  end
                end
                default: ;
              endcase
            end
          end
        end
        ST_ERR_DRAIN: begin
          if (!any_strobe) begin
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  ins_fifo #(
    .WIDTH (FRAME_W),
    .DEPTH (FIFO_DEPTH)
  ) u_ins_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (frame_word),
    .pop       (pop),
    .pop_data  (ins_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

endmodule

// File: tb/tb_core_frame_receiver.sv
// tb/tb_core_frame_receiver.sv - self-checking bench for core_frame_receiver
module tb_core_frame_receiver;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [3:0]  core_id = 4'd0;
  logic        val_ins = 1'b0;
  logic        val_mask_R0 = 1'b0;
  logic        val_mask_ac = 1'b0;
  logic        val_R0 = 1'b0;
  logic        instruction = 1'b0;
  logic        ins_ready = 1'b0;
  logic        rtr;
  logic        ins_valid;
  logic [15:0] ins_data;
  logic        core_active;
  logic        r0_load;
  logic [15:0] r0_value;
  logic        err;

  localparam logic [3:0] S_INS = 4'b1000;
  localparam logic [3:0] S_MR0 = 4'b0100;
  localparam logic [3:0] S_MAC = 4'b0010;
  localparam logic [3:0] S_R0  = 4'b0001;

  int passed = 0;
  int total  = 0;
  int pulses = 0;
  logic [15:0] mq[$];

  core_frame_receiver dut (
    .clk         (clk),
    .reset       (reset),
    .core_id     (core_id),
    .val_ins     (val_ins),
    .val_mask_R0 (val_mask_R0),
    .val_mask_ac (val_mask_ac),
    .val_R0      (val_R0),
    .instruction (instruction),
    .rtr         (rtr),
    .ins_valid   (ins_valid),
    .ins_data    (ins_data),
    .ins_ready   (ins_ready),
    .core_active (core_active),
    .r0_load     (r0_load),
    .r0_value    (r0_value),
    .err         (err)
  );

  always #5 clk = ~clk;

  // Count cycles with r0_load high, sampled mid-cycle.
  always @(negedge clk) if (!reset && r0_load === 1'b1) pulses++;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic send_bit(input logic [3:0] s, input logic b);
    {val_ins, val_mask_R0, val_mask_ac, val_R0} = s;
    instruction = b;
    tick();
  endtask

  task automatic send_frame(input logic [3:0] s, input logic [15:0] d);
    for (int i = 15; i >= 0; i--) send_bit(s, d[i]);
  endtask

  task automatic idle;
    send_bit(4'b0000, 1'b0);
  endtask

  task automatic do_reset;
    {val_ins, val_mask_R0, val_mask_ac, val_R0} = 4'b0000;
    ins_ready = 1'b0;
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    mq.delete();
    tick();
  endtask

  task automatic drain(input string tag);
    int guard;
    guard = 0;
    {val_ins, val_mask_R0, val_mask_ac, val_R0} = 4'b0000;
    while (mq.size() > 0 && guard < 20) begin
      total++;
      if (ins_valid !== 1'b1 || ins_data !== mq[0])
        $display("FAIL %s_head: got valid=%b data=%h, want valid=1 data=%h", tag, ins_valid, ins_data, mq[0]);
      else passed++;
      ins_ready = 1'b1;
      tick();
      ins_ready = 1'b0;
      void'(mq.pop_front());
      guard++;
    end
    total++;
    if (ins_valid !== 1'b0) $display("FAIL %s_empty: got ins_valid=%b, want 0", tag, ins_valid);
    else passed++;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick();
    total++; if (rtr !== 1'b1) $display("FAIL reset_rtr: got %b want 1", rtr); else passed++;
    total++; if (ins_valid !== 1'b0) $display("FAIL reset_ins_valid: got %b want 0", ins_valid); else passed++;
    total++; if (ins_data !== 16'h0) $display("FAIL reset_ins_data: got %h want 0000", ins_data); else passed++;
    total++; if (core_active !== 1'b0) $display("FAIL reset_core_active: got %b want 0", core_active); else passed++;
    total++; if (r0_load !== 1'b0) $display("FAIL reset_r0_load: got %b want 0", r0_load); else passed++;
    total++; if (r0_value !== 16'h0) $display("FAIL reset_r0_value: got %h want 0000", r0_value); else passed++;
    total++; if (err !== 1'b0) $display("FAIL reset_err: got %b want 0", err); else passed++;
    reset = 1'b0;
    tick();
  endtask

  task automatic test_ins_accept;
    do_reset();
    core_id = 4'd3;
    send_frame(S_MAC, 16'h0008);
    total++; if (core_active !== 1'b1) $display("FAIL accept_active: got %b want 1", core_active); else passed++;
    send_frame(S_INS, 16'hA5C3);
    total++; if (ins_valid !== 1'b1) $display("FAIL accept_valid: got %b want 1", ins_valid); else passed++;
    total++; if (ins_data !== 16'hA5C3) $display("FAIL accept_data: got %h want a5c3", ins_data); else passed++;
    idle();
    idle();
    total++; if (ins_data !== 16'hA5C3) $display("FAIL accept_stable: got %h want a5c3", ins_data); else passed++;
    total++; if (err !== 1'b0) $display("FAIL accept_err: got %b want 0", err); else passed++;
    mq.push_back(16'hA5C3);
    drain("accept");
  endtask

  task automatic test_inactive;
    do_reset();
    core_id = 4'd3;
    send_frame(S_MAC, 16'h0004);
    total++; if (core_active !== 1'b0) $display("FAIL inactive_active: got %b want 0", core_active); else passed++;
    send_frame(S_INS, 16'h1234);
    idle();
    total++; if (ins_valid !== 1'b0) $display("FAIL inactive_valid: got %b want 0", ins_valid); else passed++;
    total++; if (err !== 1'b0) $display("FAIL inactive_err: got %b want 0", err); else passed++;
  endtask

  task automatic test_r0;
    int p0;
    do_reset();
    core_id = 4'd0;
    send_frame(S_MR0, 16'h0001);
    p0 = pulses;
    send_frame(S_R0, 16'hBEEF);
    total++; if (r0_load !== 1'b1) $display("FAIL r0_pulse_high: got %b want 1", r0_load); else passed++;
    total++; if (r0_value !== 16'hBEEF) $display("FAIL r0_value: got %h want beef", r0_value); else passed++;
    idle();
    total++; if (r0_load !== 1'b0) $display("FAIL r0_pulse_low: got %b want 0", r0_load); else passed++;
    idle();
    total++; if (pulses - p0 !== 1) $display("FAIL r0_pulse_len: got %0d cycles want 1", pulses - p0); else passed++;
    core_id = 4'd1;
    send_frame(S_MR0, 16'h0001);
    p0 = pulses;
    send_frame(S_R0, 16'h1111);
    idle();
    idle();
    total++; if (pulses - p0 !== 0) $display("FAIL r0_unsel_pulse: got %0d cycles want 0", pulses - p0); else passed++;
    total++; if (r0_value !== 16'hBEEF) $display("FAIL r0_unsel_value: got %h want beef", r0_value); else passed++;
  endtask

  task automatic test_back_to_back;
    logic [15:0] d;
    logic        exp_rtr;
    do_reset();
    core_id = 4'd3;
    send_frame(S_MAC, 16'h0008);
    for (int k = 0; k < 8; k++) begin
      d = 16'($urandom);
      send_bit(S_INS, d[15]);
      exp_rtr = (mq.size() <= 6);
      total++; if (rtr !== exp_rtr) $display("FAIL bp_rtr_frame%0d: got %b want %b", k, rtr, exp_rtr); else passed++;
      for (int i = 14; i >= 0; i--) send_bit(S_INS, d[i]);
      mq.push_back(d);
      if (k == 6) begin
        total++; if (rtr !== 1'b1) $display("FAIL bp_rtr_between: got %b want 1", rtr); else passed++;
      end
    end
    total++; if (rtr !== 1'b0) $display("FAIL bp_rtr_full: got %b want 0", rtr); else passed++;
    total++; if (err !== 1'b0) $display("FAIL bp_err_before: got %b want 0", err); else passed++;
    send_frame(S_INS, 16'h9999);
    total++; if (err !== 1'b1) $display("FAIL bp_overflow_err: got %b want 1", err); else passed++;
    drain("bp");
    total++; if (err !== 1'b1) $display("FAIL bp_err_sticky: got %b want 1", err); else passed++;
  endtask

  task automatic test_abort;
    do_reset();
    core_id = 4'd3;
    send_frame(S_MAC, 16'h0008);
    for (int i = 0; i < 7; i++) send_bit(S_INS, 1'b1);
    idle();
    send_frame(S_INS, 16'h00FF);
    mq.push_back(16'h00FF);
    total++; if (err !== 1'b0) $display("FAIL abort_drop_err: got %b want 0", err); else passed++;
    drain("abort_drop");
    for (int i = 0; i < 5; i++) send_bit(S_INS, 1'b1);
    send_frame(S_MAC, 16'h0000);
    total++; if (core_active !== 1'b0) $display("FAIL abort_switch_active: got %b want 0", core_active); else passed++;
    total++; if (err !== 1'b0) $display("FAIL abort_switch_err: got %b want 0", err); else passed++;
    send_frame(S_MAC, 16'h0008);
    send_bit(S_INS | S_R0, 1'b1);
    total++; if (err !== 1'b1) $display("FAIL abort_multi_err: got %b want 1", err); else passed++;
    send_frame(S_INS, 16'hDEAD);
    idle();
    send_frame(S_INS, 16'h4242);
    mq.push_back(16'h4242);
    drain("abort_recover");
  endtask

  task automatic test_random;
    int          cid;
    int          t;
    int          p0;
    int          exp_pulses;
    logic [15:0] d;
    logic        exp_active;
    logic        exp_sel;
    logic [15:0] exp_r0;
    do_reset();
    cid = $urandom_range(0, 15);
    core_id = 4'(cid);
    exp_active = 1'b0;
    exp_sel = 1'b0;
    exp_r0 = 16'h0;
    exp_pulses = 0;
    p0 = pulses;
    for (int n = 0; n < 60; n++) begin
      t = $urandom_range(0, 3);
      d = 16'($urandom);
      if ($urandom_range(0, 1) == 1) d[cid] = 1'b1;
      send_frame(S_INS >> t, d);
      case (t)
        0: if (exp_active) mq.push_back(d);
        1: exp_sel = d[cid];
        2: exp_active = d[cid];
        default: if (exp_sel) begin exp_r0 = d; exp_pulses++; end
      endcase
      total++; if (core_active !== exp_active) $display("FAIL rand_active_%0d: got %b want %b", n, core_active, exp_active); else passed++;
      total++; if (r0_value !== exp_r0) $display("FAIL rand_r0_%0d: got %h want %h", n, r0_value, exp_r0); else passed++;
      total++; if (ins_valid !== (mq.size() != 0)) $display("FAIL rand_valid_%0d: got %b want %b", n, ins_valid, mq.size() != 0); else passed++;
      if (mq.size() != 0) begin
        total++; if (ins_data !== mq[0]) $display("FAIL rand_head_%0d: got %h want %h", n, ins_data, mq[0]); else passed++;
      end
      if ($urandom_range(0, 2) == 0) idle();
      if (mq.size() >= 6) drain("rand");
    end
    idle();
    drain("rand_final");
    total++; if (pulses - p0 !== exp_pulses) $display("FAIL rand_pulses: got %0d want %0d", pulses - p0, exp_pulses); else passed++;
    total++; if (err !== 1'b0) $display("FAIL rand_err: got %b want 0", err); else passed++;
  endtask

  task automatic test_reset_mid;
    do_reset();
    core_id = 4'd3;
    send_frame(S_MAC, 16'h0008);
    send_frame(S_INS, 16'h1111);
    send_frame(S_INS, 16'h2222);
    send_frame(S_INS, 16'h3333);
    for (int i = 0; i < 5; i++) send_bit(S_INS, 1'b1);
    total++; if (ins_valid !== 1'b1) $display("FAIL rmid_pre_valid: got %b want 1", ins_valid); else passed++;
    #2;
    reset = 1'b1;
    #1;
    total++; if (rtr !== 1'b1) $display("FAIL rmid_rtr: got %b want 1", rtr); else passed++;
    total++; if (ins_valid !== 1'b0) $display("FAIL rmid_valid: got %b want 0", ins_valid); else passed++;
    total++; if (ins_data !== 16'h0) $display("FAIL rmid_data: got %h want 0000", ins_data); else passed++;
    total++; if (core_active !== 1'b0) $display("FAIL rmid_active: got %b want 0", core_active); else passed++;
    total++; if (r0_load !== 1'b0 || r0_value !== 16'h0) $display("FAIL rmid_r0: got load=%b value=%h want 0/0000", r0_load, r0_value); else passed++;
    total++; if (err !== 1'b0) $display("FAIL rmid_err: got %b want 0", err); else passed++;
    {val_ins, val_mask_R0, val_mask_ac, val_R0} = 4'b0000;
    tick();
    reset = 1'b0;
    mq.delete();
    tick();
    send_frame(S_MAC, 16'h0008);
    send_frame(S_INS, 16'h5A5A);
    mq.push_back(16'h5A5A);
    drain("rmid_after");
  endtask

  initial begin
    test_reset();
    test_ins_accept();
    test_inactive();
    test_r0();
    test_back_to_back();
    test_abort();
    test_random();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/core_frame_receiver.md
# core_frame_receiver

Per-core front end that sits directly downstream of the scheduler's serial broadcast and upstream of each `gpu_core`'s execute logic. It deserialises the 1-bit `instruction` stream into 16-bit frames, classifies each frame by which of the four valid strobes framed it, and latches the R0-load mask, active mask and R0 value. Instruction frames for active cores go into a small FIFO. It drives `rtr` back to the scheduler as flow control; the scheduler ANDs `rtr` across all cores.

## Interface
- `FRAME_W`, 16, frame width in bits (serial bits per frame)
- `FIFO_DEPTH`, 8, instruction FIFO entries (power of two, ≥2)
- `CORE_ID_W`, 4, width of `core_id`; mask frames carry one bit per core (2**CORE_ID_W = FRAME_W)
- `clk` in 1: single clock, rising edge
- `reset` in 1: asynchronous, active-high; clears all state
- `core_id` in CORE_ID_W: static core index, selects this core's bit in mask frames
- `val_ins` in 1: current bit belongs to an instruction frame
- `val_mask_R0` in 1: current bit belongs to an R0-load mask frame
- `val_mask_ac` in 1: current bit belongs to an active-core mask frame
- `val_R0` in 1: current bit belongs to an R0 value frame
- `instruction` in 1: serial data bit, MSB first
- `rtr` out 1: ready to receive another instruction frame
- `ins_valid` out 1: FIFO head valid
- `ins_data` out FRAME_W: FIFO head instruction
- `ins_ready` in 1: core consumes head when `ins_valid & ins_ready`
- `core_active` out 1: this core's bit of the last active mask
- `r0_load` out 1: one-cycle pulse, `r0_value` updated
- `r0_value` out FRAME_W: last accepted R0 value
- `err` out 1: sticky protocol/overflow error, cleared only by reset

## Operation
- FSM states: IDLE, SHIFT, ERR_DRAIN.
- IDLE: when exactly one strobe is high, shift in bit, record frame type, set count=1, go to SHIFT.
- SHIFT: the same single strobe is high each cycle; shift left, insert `instruction` at LSB, count+1. On count==FRAME_W−1 with strobe high, frame completes this cycle and FSM returns to IDLE.
- Abort: in SHIFT, if all strobes drop, or a different strobe rises, the partial frame is discarded and `err` is not set for the drop case. If a different single strobe rises, it starts a new frame in the same cycle (count=1).
- More than one strobe high in any cycle: set `err`, discard partial, go to ERR_DRAIN; remain until all strobes low, then IDLE.
- On frame completion:
  - mask_ac frame: `core_active` ← frame[core_id].
  - mask_R0 frame: internal `r0_sel` ← frame[core_id].
  - R0 frame: if `r0_sel`, `r0_value` ← frame and pulse `r0_load`; otherwise ignore.
  - ins frame: if `core_active`, push into FIFO; otherwise drop silently.
- Push into a full FIFO with no pop that cycle: frame dropped, `err` set. Push and pop in the same cycle while full: both succeed.
- `rtr` = FIFO occupancy ≤ FIFO_DEPTH−2, or occupancy == FIFO_DEPTH−1 and no frame in progress. This guarantees space for one full frame.
- Count and FIFO pointers wrap modulo their widths; occupancy counter is $clog2(FIFO_DEPTH)+1 bits.

## Timing
- Reset values: `rtr`=1, `ins_valid`=0, `ins_data`=0, `core_active`=0, `r0_load`=0, `r0_value`=0, `err`=0, `r0_sel`=0, FSM=IDLE, count=0.
- Latency: last bit sampled at edge N → mask/R0 registers and FIFO write visible after edge N (same edge). `ins_valid` rises the cycle after an empty-FIFO push.
- FIFO is first-word registered: `ins_data` is stable while `ins_valid & !ins_ready`.
- `r0_load` is high for exactly one cycle per accepted R0 frame.
- Back-to-back frames with no idle gap are legal: new frame's first bit may occur the cycle after completion.
- Reset asserted mid-frame: partial frame lost, FIFO emptied, outputs return to reset values asynchronously.

## Structure
- Shared package `gpu_pkg`: frame type enum (FT_INS, FT_MASK_R0, FT_MASK_AC, FT_R0), `FRAME_W` constant. The scheduler reuses both.
- One sub-module: `ins_fifo` (synchronous FIFO, parameterised width/depth, full/empty/count). The deserialiser FSM lives in the top.

## Test plan
- core_id=3: send mask_ac 0x0008, then ins 0xA5C3 → `ins_valid`=1, `ins_data`=0xA5C3 one cycle after last bit.
- core_id=3: send mask_ac 0x0004, then ins 0x1234 → FIFO stays empty, `err`=0.
- Send mask_R0 0x0001 with core_id=0, then R0 0xBEEF → single `r0_load` pulse, `r0_value`=0xBEEF. Repeat with core_id=1 → no pulse, value unchanged.
- Active core, `ins_ready`=0: send 8 instruction frames back-to-back → `rtr` drops as occupancy reaches 7 and a frame is in progress. A forced 9th frame → dropped, `err`=1.
- Drop `val_ins` after 7 bits, then a full frame 0x00FF → only 0x00FF queued. Raise `val_ins` and `val_R0` together → `err`=1, FSM recovers once strobes go low.
- Assert `reset` mid-frame with 3 entries queued → all outputs return to reset values, `rtr`=1.
